// File: rtl/pc_sequencer.sv
// Program counter and next-PC sequencer for the RV32I single-cycle core.
// Selects the redirect target, traps misaligned transfers and counts retired branches.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             is_branch,
    input  logic             take_branch,
    input  logic             is_jal,
    input  logic             is_jalr,
    input  logic [31:0]      imm,
    input  logic [31:0]      rs1_val,
    input  logic             trap_ack,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic [31:0]      next_pc,
    output logic             misalign_trap,
    output logic [31:0]      trap_pc,
    output logic [31:0]      trap_target,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [31:0] branch_target;
    logic [31:0] jalr_sum;
    logic [31:0] target;
    logic        redirect;
    logic        branch_sel;
    logic        misaligned;
    logic        retire;
    logic        trap_capture;

    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc + imm;
    assign jalr_sum      = rs1_val + imm;

    always_comb begin
        target     = pc_plus4;
        redirect   = 1'b0;
        branch_sel = 1'b0;
        if (is_jalr) begin
            target   = {jalr_sum[31:1], 1'b0};
            redirect = 1'b1;
        end else if (is_jal) begin
            target   = branch_target;
            redirect = 1'b1;
        end else if (is_branch && take_branch) begin
            target     = branch_target;
            redirect   = 1'b1;
            branch_sel = 1'b1;
        end
    end

    // Only a redirect that is actually taken can fault.
    assign misaligned = redirect && (target[1:0] != 2'b00);

    always_comb begin
        state_nxt    = state;
        next_pc      = pc;
        retire       = 1'b0;
        trap_capture = 1'b0;
        case (state)
            RUN: begin
                if (!stall) begin
                    if (misaligned) begin
                        state_nxt    = TRAP;
                        trap_capture = 1'b1;
                    end else begin
                        next_pc = target;
                        retire  = 1'b1;
                    end
                end
            end
            TRAP: begin
                if (trap_ack) begin
                    state_nxt = RUN;
                    next_pc   = TRAP_VEC;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    assign misalign_trap = (state == TRAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            trap_pc      <= 32'd0;
            trap_target  <= 32'd0;
            branch_count <= '0;
            taken_count  <= '0;
        end else begin
            pc <= next_pc;
            if (trap_capture) begin
                trap_pc     <= pc;
                trap_target <= target;
            end
            if (retire && is_branch)  branch_count <= branch_count + CNT_W'(1);
            if (retire && branch_sel) taken_count  <= taken_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter register and next-PC sequencer for the RV32I single-cycle core. It sits directly downstream of the branch comparator and consumes its `take_branch` decision together with jump decode and the immediate. From these it selects and registers the next instruction address. It also detects misaligned control-transfer targets, holds fetch in a trap state until acknowledged, and keeps branch/taken statistics counters.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `TRAP_VEC`, default 32'h0000_0100: PC value loaded when a misalignment trap is acknowledged.
- `CNT_W`, default 32: width of the statistics counters.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold the PC and counters this cycle (RUN state only).
- `is_branch`  in  1  current instruction is a conditional branch.
- `take_branch`  in  1  branch condition result from the branch comparator.
- `is_jal`  in  1  current instruction is JAL.
- `is_jalr`  in  1  current instruction is JALR.
- `imm`  in  32  sign-extended B/J/I immediate of the current instruction.
- `rs1_val`  in  32  rs1 operand, used by JALR.
- `trap_ack`  in  1  acknowledge of a pending misalignment trap.
- `pc`  out  32  registered PC of the current instruction.
- `pc_plus4`  out  32  combinational `pc + 4`, used as the link value.
- `next_pc`  out  32  combinational value `pc` will take at the next edge.
- `misalign_trap`  out  1  registered; high while in the TRAP state.
- `trap_pc`  out  32  registered PC of the faulting instruction.
- `trap_target`  out  32  registered misaligned target that caused the trap.
- `branch_count`  out  CNT_W  number of retired conditional branches.
- `taken_count`  out  CNT_W  number of retired taken conditional branches.

## Operation
- Two states, RUN and TRAP. Reset enters RUN.
- Target computation (all 32-bit, modulo 2^32):
  - branch/JAL: `pc + imm`.
  - JALR: `(rs1_val + imm) & ~32'h1`.
- Redirect selection priority: `is_jalr` > `is_jal` > (`is_branch` & `take_branch`) > sequential `pc_plus4`.
- `take_branch` is ignored when `is_branch` is 0.
- Misalignment: a redirect is misaligned when `target[1:0] != 2'b00` (IALIGN = 32, no C extension). It is checked only on a redirect that is actually taken. A not-taken branch with a misaligned target is not a trap.
- RUN, `stall` = 1:
  - `next_pc = pc`.
  - No state, counter, or trap register changes.
- RUN, `stall` = 0, no misalignment:
  - `pc <= next_pc`.
  - If `is_branch`: `branch_count` +1.
  - If `is_branch` & `take_branch` and the branch is the selected redirect: `taken_count` +1.
- RUN, `stall` = 0, misaligned redirect:
  - `pc` is held.
  - `trap_pc <= pc` and `trap_target <= target`.
  - State goes to TRAP.
  - Counters are not incremented (the instruction does not retire).
- TRAP:
  - `pc` is held and `next_pc = pc`.
  - All instruction inputs and `stall` are ignored.
  - On `trap_ack` = 1: `pc <= TRAP_VEC` and state goes to RUN.
- `trap_pc` and `trap_target` keep their values until overwritten by the next trap.
- Counters wrap from 2^CNT_W−1 to 0.
- PC wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- Reset (async, `rst_n` low) sets, immediately and independent of `clk`:
  - `pc = RESET_PC`, state RUN, `misalign_trap = 0`.
  - `trap_pc = 0`, `trap_target = 0`, both counters = 0.
- Outputs settle after `rst_n` deasserts; the first update occurs on the first rising edge with `rst_n` high.
- Redirect latency: 1 cycle. The target presented on `next_pc` in cycle N is on `pc` in cycle N+1.
- `misalign_trap` rises at the edge that detects the fault and stays high until the edge that samples `trap_ack` = 1. `pc = TRAP_VEC` appears at that same edge.
- `trap_ack` asserted in RUN has no effect.
- `trap_ack` asserted in the same cycle the trap is detected has no effect; the ack must arrive at least 1 cycle later.
- Reset asserted mid-TRAP aborts the trap immediately and returns to the reset values.
- `pc_plus4` and `next_pc` are purely combinational from current state and inputs.

## Test plan
- Reset with `RESET_PC` = 0, then 3 unstalled cycles with no control flow -> `pc` = 0, 4, 8, 0xC; counters stay 0.
- `pc` = 0x100, `is_branch` = 1, `take_branch` = 1, `imm` = 0xFFFF_FFF0 -> `pc` = 0xF0 next cycle; `branch_count` = 1, `taken_count` = 1.
- `pc` = 0x200, `is_branch` = 1, `take_branch` = 0, `imm` = 0x6 -> `pc` = 0x204, no trap; `branch_count` +1, `taken_count` unchanged.
- JALR with `rs1_val` = 0x1001, `imm` = 0x4 -> `pc` = 0x1004 (bit 0 cleared).
- JAL with `pc` = 0x300, `imm` = 0x2 -> `misalign_trap` = 1, `trap_pc` = 0x300, `trap_target` = 0x302, `pc` held for 3 cycles. `trap_ack` = 1 -> `pc` = 0x100, `misalign_trap` = 0.
- `stall` held 2 cycles during a taken branch -> `pc` and counters frozen; the redirect happens on the first unstalled edge. `rst_n` pulsed low mid-TRAP -> all outputs return to reset values without waiting for a clock edge.
